to_lower_stream: RTL and testbench
==================================

TO_LOWER_STREAM -- requirements
Module: to_lower_stream

Interface
REQ-001 Parameter: DEPTH, 4, number of entries in the output buffer; legal values 2, 4, 8.
REQ-002 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: in_data  input  8  incoming ASCII byte.
REQ-005 Port: in_valid  input  1  in_data is valid this cycle.
REQ-006 Port: in_ready  output  1  block can accept a byte this cycle.
REQ-007 Port: out_data  output  8  converted byte at the buffer head.
REQ-008 Port: out_valid  output  1  out_data is valid.
REQ-009 Port: out_ready  input  1  downstream accepts out_data this cycle.
REQ-010 Port: clr_counts  input  1  synchronous clear of both statistics counters.
REQ-011 Port: level  output  4  number of occupied buffer entries, 0..DEPTH.
REQ-012 Port: conv_count  output  16  accepted bytes that were case-converted; saturating.
REQ-013 Port: hi_count  output  16  accepted bytes with bit 7 set; saturating.

Function
REQ-014 Accept: in_valid=1 and in_ready=1 at a clock edge.
REQ-015 Emit: out_valid=1 and out_ready=1 at a clock edge.
REQ-016 Conversion: accepted byte in 0x41..0x5A ('A'..'Z') is stored as byte | 0x20; every other byte, including 0x80..0xFF, is stored unchanged.
REQ-017 Conversion applies at acceptance; the buffer holds converted bytes only.
REQ-018 Buffer: circular FIFO of DEPTH entries with read and write pointers that wrap from DEPTH-1 to 0; strict arrival order.
REQ-019 in_ready = (level < DEPTH); registered state only, with no combinational path from out_ready or in_valid.
REQ-020 out_valid = (level != 0); out_data = entry at the read pointer.
REQ-021 Latency: a byte accepted at edge N is visible on out_data with out_valid=1 after edge N (one cycle) when the buffer was empty.
REQ-022 While out_valid=1 and out_ready=0, out_data and out_valid hold stable.
REQ-023 Accept and emit at the same edge: level unchanged; both pointers advance.
REQ-024 Full (level=DEPTH): in_ready=0; in_valid is ignored; no overwrite.
REQ-025 Empty (level=0): out_ready is ignored; no pointer movement or underflow.
REQ-026 conv_count increments by 1 on each accept of a byte in 0x41..0x5A; it holds at 0xFFFF once reached.
REQ-027 hi_count increments by 1 on each accept of a byte with bit 7 = 1; it holds at 0xFFFF once reached.
REQ-028 clr_counts=1 sets both counters to 0 at that edge; clear takes priority over a simultaneous increment.
REQ-029 clr_counts does not affect buffer contents, pointers, level or the handshake.
REQ-030 Throughput: one byte per cycle in each direction sustained while out_ready=1.

Reset
REQ-031 rst=1 at an edge: pointers=0, level=0, out_valid=0, in_ready=1, conv_count=0, hi_count=0.
REQ-032 Reset mid-stream discards all buffered bytes; accepts and emits during the rst=1 cycle are ignored.
REQ-033 out_data value is don't-care while out_valid=0.
REQ-034 Reset takes priority over clr_counts and over all handshake activity.

Verification
REQ-035 Stream "Hello, WORLD!" with out_ready=1 -> out_data sequence "hello, world!", one cycle latency, conv_count=6, hi_count=0.
REQ-036 Boundaries 0x40, 0x41, 0x5A, 0x5B, 0x60, 0x7A -> outputs 0x40, 0x61, 0x7A, 0x5B, 0x60, 0x7A; conv_count=2.
REQ-037 out_ready=0, push DEPTH+2 bytes -> in_ready falls after DEPTH accepts, level=DEPTH, no overwrite; release out_ready -> all DEPTH bytes emitted in order.
REQ-038 Bytes 0xC1, 0xFF, 0x41 -> outputs 0xC1, 0xFF, 0x61; hi_count=2, conv_count=1.
REQ-039 With level=3, assert rst for one cycle -> out_valid=0, level=0, in_ready=1 next cycle; a later "AB" yields "ab".
REQ-040 Preload conv_count=0xFFFE, accept 3 uppercase bytes -> 0xFFFF; clr_counts plus uppercase accept in the same cycle -> conv_count=0.

Source files
------------

// File: rtl/to_lower_stream.sv
// Byte stream filter that folds ASCII 'A'..'Z' to lowercase into a circular output
// buffer, with saturating statistics for converted and high-bit bytes.
module to_lower_stream #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        clr_counts,
  output logic [3:0]  level,
  output logic [15:0] conv_count,
  output logic [15:0] hi_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [3:0]    r_level;
  logic [15:0]   r_conv_count;
  logic [15:0]   r_hi_count;

  logic w_accept;
  logic w_emit;
  logic w_is_upper;

  function automatic logic is_upper(input logic [7:0] b);
    return (b >= 8'h41) && (b <= 8'h5A);
  endfunction

  function automatic logic [7:0] to_lower(input logic [7:0] b);
    return is_upper(b) ? (b | 8'h20) : b;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Handshake flags come from registered occupancy only.
  assign in_ready   = (r_level < 4'(DEPTH));
  assign out_valid  = (r_level != 4'd0);
  assign out_data   = r_mem[r_rd_ptr];
  assign level      = r_level;
  assign conv_count = r_conv_count;
  assign hi_count   = r_hi_count;

  assign w_accept   = in_valid && in_ready;
  assign w_emit     = out_valid && out_ready;
  assign w_is_upper = is_upper(in_data);

  // Storage holds already-converted bytes; stale writes during reset are harmless.
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wr_ptr] <= to_lower(in_data);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= 4'd0;
    end else begin
      if (w_accept) r_wr_ptr <= ptr_next(r_wr_ptr);
      if (w_emit)   r_rd_ptr <= ptr_next(r_rd_ptr);
      case ({w_accept, w_emit})
        2'b10:   r_level <= r_level + 4'd1;
        2'b01:   r_level <= r_level - 4'd1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Clear wins over a same-edge increment.
  always_ff @(posedge clk) begin
    if (rst || clr_counts) begin
      r_conv_count <= 16'd0;
      r_hi_count   <= 16'd0;
    end else begin
      if (w_accept && w_is_upper) r_conv_count <= sat_inc(r_conv_count);
      if (w_accept && in_data[7]) r_hi_count   <= sat_inc(r_hi_count);
    end
  end

endmodule

// File: tb/tb_to_lower_stream.sv
// Scoreboard bench for to_lower_stream: driver queues expected bytes on accept,
// monitor pops and compares on every emit.
module tb_to_lower_stream;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        clr_counts;
  logic [3:0]  level;
  logic [15:0] conv_count;
  logic [15:0] hi_count;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  to_lower_stream #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .clr_counts(clr_counts), .level(level),
    .conv_count(conv_count), .hi_count(hi_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: an emit happens at the next rising edge when valid&ready here.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL out_unexpected: got %0h expected nothing", out_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("out_data", {24'd0, out_data}, {24'd0, e});
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic [7:0] e);
    bit done = 0;
    in_data  = b;
    in_valid = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: got no accept expected accept of %0h", b);
    end
  endtask

  task automatic wait_empty();
    bit done = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (level == 4'd0 && exp_q.size() == 0) done = 1;
    end
    @(posedge clk);
    #1;
    chk("drain_done", {31'd0, done}, 32'd1);
  endtask

  task automatic clear_counts();
    clr_counts = 1'b1;
    @(posedge clk);
    #1;
    clr_counts = 1'b0;
    chk("clr_conv", {16'd0, conv_count}, 32'd0);
    chk("clr_hi", {16'd0, hi_count}, 32'd0);
  endtask

  initial begin
    string hin, hexp;
    logic [7:0] bin [6];
    logic [7:0] bexp[6];
    logic [7:0] fin [6];
    logic [7:0] fexp[6];
    int acc;
    int n;

    rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b0; clr_counts = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_level", {28'd0, level}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_conv", {16'd0, conv_count}, 32'd0);
    chk("rst_hi", {16'd0, hi_count}, 32'd0);

    // Hello stream with one-cycle latency on the first byte
    hin  = "Hello, WORLD!";
    hexp = "hello, world!";
    out_ready = 1'b1;
    send(hin[0], hexp[0]);
    chk("lat_out_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_out_data", {24'd0, out_data}, {24'd0, 8'h68});
    for (int i = 1; i < hin.len(); i++) send(hin[i], hexp[i]);
    wait_empty();
    chk("hello_conv", {16'd0, conv_count}, 32'd6);
    chk("hello_hi", {16'd0, hi_count}, 32'd0);
    clear_counts();

    // Range boundaries around 'A'..'Z'
    bin  = '{8'h40, 8'h41, 8'h5A, 8'h5B, 8'h60, 8'h7A};
    bexp = '{8'h40, 8'h61, 8'h7A, 8'h5B, 8'h60, 8'h7A};
    for (int i = 0; i < 6; i++) send(bin[i], bexp[i]);
    wait_empty();
    chk("bound_conv", {16'd0, conv_count}, 32'd2);
    chk("bound_hi", {16'd0, hi_count}, 32'd0);
    clear_counts();

    // High-bit bytes pass through unchanged
    send(8'hC1, 8'hC1);
    send(8'hFF, 8'hFF);
    send(8'h41, 8'h61);
    wait_empty();
    chk("hi_hi", {16'd0, hi_count}, 32'd2);
    chk("hi_conv", {16'd0, conv_count}, 32'd1);
    clear_counts();

    // Fill with output stalled; extra bytes must be refused
    fin  = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56};
    fexp = '{8'h71, 8'h72, 8'h73, 8'h74, 8'h75, 8'h76};
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      in_data  = fin[acc];
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(fexp[acc]);
        acc++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("full_accepts", acc, DEPTH);
    chk("full_level", {28'd0, level}, DEPTH);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("full_out_valid", {31'd0, out_valid}, 32'd1);
    chk("full_head_hold", {24'd0, out_data}, {24'd0, 8'h71});
    chk("full_conv", {16'd0, conv_count}, DEPTH);
    out_ready = 1'b1;
    wait_empty();
    clear_counts();

    // Reset with three bytes buffered and handshakes active
    out_ready = 1'b0;
    send(8'h78, 8'h78);
    send(8'h79, 8'h79);
    send(8'h7A, 8'h7A);
    chk("pre_rst_level", {28'd0, level}, 32'd3);
    rst = 1'b1; in_data = 8'h51; in_valid = 1'b1; out_ready = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_level", {28'd0, level}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    send(8'h41, 8'h61);
    send(8'h42, 8'h62);
    wait_empty();
    clear_counts();

    // Drive conv_count to 0xFFFE with back-to-back uppercase accepts
    n = 0;
    in_data  = 8'h41;
    in_valid = 1'b1;
    for (int k = 0; k < 70000 && n < 65534; k++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(8'h61);
        n++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("sat_preload", {16'd0, conv_count}, 32'hFFFE);
    send(8'h41, 8'h61);
    send(8'h42, 8'h62);
    send(8'h43, 8'h63);
    chk("sat_hold", {16'd0, conv_count}, 32'hFFFF);
    in_data = 8'h44; in_valid = 1'b1; clr_counts = 1'b1;
    @(negedge clk);
    if (in_ready) exp_q.push_back(8'h64);
    @(posedge clk);
    #1;
    in_valid = 1'b0; clr_counts = 1'b0;
    chk("clr_priority", {16'd0, conv_count}, 32'd0);
    wait_empty();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
